// File: rtl/hpi_access_arbiter.sv
// hpi_access_arbiter: sequences CY7C67200 HPI bus cycles and shares the port between two
// requesters (0 = Nios PIO bridge, 1 = hardware keycode poller) with round-robin arbitration.
// Bus timing comes from SETUP/STROBE/HOLD/RECOVERY cycle counts; every pad output is registered.
// Optional feature: define HPI_LOCK_EN to let a requester hold the grant across accesses
// (lock sampled when its access completes) so address-write/data-read pairs stay atomic.
module hpi_access_arbiter #(
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned STROBE_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned RECOVERY_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       we_i,
  input  logic [1:0][1:0]  addr_i,
  input  logic [1:0][15:0] wdata_i,
  input  logic [1:0]       lock_i,
  output logic [1:0]       ack_o,
  output logic [1:0][15:0] rdata_o,
  output logic             busy_o,
  output logic [1:0]       hpi_addr_o,
  output logic             hpi_cs_n_o,
  output logic             hpi_rd_n_o,
  output logic             hpi_wr_n_o,
  output logic [15:0]      hpi_dout_o,
  output logic             hpi_dout_en_o,
  input  logic [15:0]      hpi_din_i
);

  localparam int unsigned MaxSh  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxSr  = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES
                                                                     : RECOVERY_CYCLES;
  localparam int unsigned MaxCyc = (MaxSh > MaxSr) ? MaxSh : MaxSr;
  localparam int unsigned CntW   = (MaxCyc < 1) ? 1 : $clog2(MaxCyc + 1);

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] RecLd    = CntW'((RECOVERY_CYCLES == 0) ? 0 : RECOVERY_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StDone,
    StRecover
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             grant_q;
  logic             last_q;
  logic             we_q;
  logic [15:0]      rd_buf_q;
  logic [1:0]       ack_q;
  logic [1:0][15:0] rdata_q;
  logic [1:0]       hpi_addr_q;
  logic             hpi_cs_n_q;
  logic             hpi_rd_n_q;
  logic             hpi_wr_n_q;
  logic [15:0]      hpi_dout_q;
  logic             hpi_dout_en_q;

  logic             gnt_valid;
  logic             gnt_idx;

`ifdef HPI_LOCK_EN
  logic             locked_q;
`else
  logic             unused_lock;
  assign unused_lock = ^lock_i;
`endif

  // Arbitration: single requester wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_valid = |req_i;
    gnt_idx   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = req_i[1];
    end
`ifdef HPI_LOCK_EN
    // A locked owner that still requests keeps the port; the other requester waits.
    if (locked_q && req_i[grant_q]) begin
      gnt_idx = grant_q;
    end
`endif
  end

  // Access sequencer: state, phase counter and all registered pad/handshake outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      we_q          <= 1'b0;
      rd_buf_q      <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      hpi_addr_q    <= '0;
      hpi_cs_n_q    <= 1'b1;
      hpi_rd_n_q    <= 1'b1;
      hpi_wr_n_q    <= 1'b1;
      hpi_dout_q    <= '0;
      hpi_dout_en_q <= 1'b0;
`ifdef HPI_LOCK_EN
      locked_q      <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
`ifdef HPI_LOCK_EN
          if (locked_q && !req_i[grant_q]) begin
            locked_q <= 1'b0;
          end
`endif
          if (gnt_valid) begin
            grant_q    <= gnt_idx;
            last_q     <= gnt_idx;
            we_q       <= we_i[gnt_idx];
            hpi_addr_q <= addr_i[gnt_idx];
            hpi_cs_n_q <= 1'b0;
            if (we_i[gnt_idx]) begin
              hpi_dout_q    <= wdata_i[gnt_idx];
              hpi_dout_en_q <= 1'b1;
            end
            cnt_q   <= SetupLd;
            state_q <= StSetup;
          end
        end

        StSetup: begin
          if (cnt_q == '0) begin
            if (we_q) begin
              hpi_wr_n_q <= 1'b0;
            end else begin
              hpi_rd_n_q <= 1'b0;
            end
            cnt_q   <= StrobeLd;
            state_q <= StStrobe;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StStrobe: begin
          if (cnt_q == '0) begin
            // Final strobe cycle: capture the pad before the strobe rises.
            if (!we_q) begin
              rd_buf_q <= hpi_din_i;
            end
            hpi_rd_n_q <= 1'b1;
            hpi_wr_n_q <= 1'b1;
            cnt_q      <= HoldLd;
            state_q    <= StHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StHold: begin
          if (cnt_q == '0) begin
            hpi_cs_n_q     <= 1'b1;
            hpi_dout_en_q  <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            if (!we_q) begin
              rdata_q[grant_q] <= rd_buf_q;
            end
`ifdef HPI_LOCK_EN
            locked_q <= lock_i[grant_q];
`endif
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        StDone: begin
          cnt_q <= RecLd;
          if (RECOVERY_CYCLES == 0) begin
            state_q <= StIdle;
          end else begin
            state_q <= StRecover;
          end
        end

        StRecover: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack_o         = ack_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = (state_q != StIdle);
  assign hpi_addr_o    = hpi_addr_q;
  assign hpi_cs_n_o    = hpi_cs_n_q;
  assign hpi_rd_n_o    = hpi_rd_n_q;
  assign hpi_wr_n_o    = hpi_wr_n_q;
  assign hpi_dout_o    = hpi_dout_q;
  assign hpi_dout_en_o = hpi_dout_en_q;

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Self-checking bench for hpi_access_arbiter at default timing.
// Expected completions are queued when an access is launched and matched against ack pulses.
module tb_hpi_access_arbiter;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [1:0]       req_i = '0;
  logic [1:0]       we_i = '0;
  logic [1:0][1:0]  addr_i = '0;
  logic [1:0][15:0] wdata_i = '0;
  logic [1:0]       lock_i = '0;
  logic [1:0]       ack_o;
  logic [1:0][15:0] rdata_o;
  logic             busy_o;
  logic [1:0]       hpi_addr_o;
  logic             hpi_cs_n_o;
  logic             hpi_rd_n_o;
  logic             hpi_wr_n_o;
  logic [15:0]      hpi_dout_o;
  logic             hpi_dout_en_o;
  logic [15:0]      hpi_din_i = '0;

  hpi_access_arbiter dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .lock_i       (lock_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .hpi_addr_o   (hpi_addr_o),
    .hpi_cs_n_o   (hpi_cs_n_o),
    .hpi_rd_n_o   (hpi_rd_n_o),
    .hpi_wr_n_o   (hpi_wr_n_o),
    .hpi_dout_o   (hpi_dout_o),
    .hpi_dout_en_o(hpi_dout_en_o),
    .hpi_din_i    (hpi_din_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        idx;
    logic        we;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every ack pulse must match the oldest outstanding access.
  always @(posedge clk_i) begin
    #1;
    if (ack_o[0]) ack_cnt0++;
    if (ack_o != 2'b00) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", {30'd0, ack_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_idx", {30'd0, ack_o}, (e.idx ? 32'd2 : 32'd1));
        if (!e.we) chk("rdata", {16'd0, rdata_o[e.idx]}, {16'd0, e.data});
      end
    end
  end

  task automatic push_exp(input int idx, input bit w, input logic [15:0] d);
    exp_t e;
    e.idx  = idx[0];
    e.we   = w;
    e.data = d;
    sb.push_back(e);
  endtask

  // One complete access with pad-timing measurement.
  task automatic do_access(input int idx, input bit w, input logic [1:0] a,
                           input logic [15:0] wd, input logic [15:0] din);
    int cs_low = 0, rd_low = 0, wr_low = 0, den = 0, lat = 0, bad_addr = 0, bad_dout = 0;
    bit got = 0;
    @(negedge clk_i);
    we_i[idx]    = w;
    addr_i[idx]  = a;
    wdata_i[idx] = wd;
    hpi_din_i    = din;
    push_exp(idx, w, din);
    req_i[idx] = 1'b1;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(posedge clk_i);
      #1;
      if (!hpi_cs_n_o) begin
        cs_low++;
        if (hpi_addr_o != a) bad_addr++;
      end
      if (!hpi_rd_n_o) rd_low++;
      if (!hpi_wr_n_o) wr_low++;
      if (hpi_dout_en_o) begin
        den++;
        if (hpi_dout_o != wd) bad_dout++;
      end
      if (ack_o[idx]) begin
        got = 1;
        lat = c;
        req_i[idx] = 1'b0;
      end
    end
    chk("ack_seen", got, 1);
    chk("latency", lat, 7);
    chk("cs_low", cs_low, 6);
    chk("rd_low", rd_low, w ? 0 : 4);
    chk("wr_low", wr_low, w ? 4 : 0);
    chk("dout_en", den, w ? 6 : 0);
    chk("addr_err", bad_addr, 0);
    chk("dout_err", bad_dout, 0);
    repeat (4) @(posedge clk_i);
  endtask

  // Both requesters contend; checks completion order via scoreboard and cs_n-high gaps.
  task automatic contend(input int n_acks);
    int acks = 0, hi_run = 0, min_gap = 1000;
    bit seen_low = 0;
    for (int c = 0; c < 120 && acks < n_acks; c++) begin
      @(posedge clk_i);
      #1;
      if (hpi_cs_n_o) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        seen_low = 1;
        hi_run = 0;
      end
      if (ack_o != 2'b00) acks++;
      if (ack_o[0] && lock_i[0]) lock_i[0] = 1'b0;
      if (acks == n_acks) req_i = '0;
    end
    chk("contend_acks", acks, n_acks);
    chk("gap_ge3", (min_gap >= 3), 1);
    repeat (6) @(posedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cs_n", hpi_cs_n_o, 1);
    chk("rst_rd_n", hpi_rd_n_o, 1);
    chk("rst_wr_n", hpi_wr_n_o, 1);
    chk("rst_addr", hpi_addr_o, 0);
    chk("rst_dout", hpi_dout_o, 0);
    chk("rst_dout_en", hpi_dout_en_o, 0);
    chk("rst_ack", ack_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // Basic write by requester 0, read by requester 1.
    do_access(0, 1'b1, 2'd2, 16'h1234, 16'h0000);
    do_access(1, 1'b0, 2'd0, 16'h0000, 16'hBEEF);
    chk("rdata1_after", rdata_o[1], 16'hBEEF);
    // Read by requester 0 must not disturb requester 1's read data.
    do_access(0, 1'b0, 2'd3, 16'h0000, 16'h5A5A);
    chk("rdata1_kept", rdata_o[1], 16'hBEEF);
    chk("rdata0", rdata_o[0], 16'h5A5A);

    // Reset two cycles into STROBE: strobes and cs_n release at once, no ack follows.
    @(negedge clk_i);
    we_i[1] = 1'b0;
    addr_i[1] = 2'd1;
    hpi_din_i = 16'h7777;
    req_i[1] = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("pre_rst_rd_n", hpi_rd_n_o, 0);
    #1;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_rd_n", hpi_rd_n_o, 1);
    chk("mid_rst_cs_n", hpi_cs_n_o, 1);
    chk("mid_rst_wr_n", hpi_wr_n_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rdata1", rdata_o[1], 0);
    req_i[1] = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (12) @(posedge clk_i);
    do_access(1, 1'b0, 2'd1, 16'h0000, 16'hC0DE);

    // Both requesters high from reset: order 0,1,0,1.
    @(negedge clk_i);
    reset_i = 1'b1;
    we_i = 2'b11;
    wdata_i[0] = 16'hA0A0;
    wdata_i[1] = 16'hB1B1;
    req_i = 2'b11;
    for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b1, 16'h0000);
    @(negedge clk_i);
    reset_i = 1'b0;
    contend(4);

    // Short request dropped during STROBE: exactly one access and one ack.
    @(negedge clk_i);
    ack_cnt0 = 0;
    we_i[0] = 1'b1;
    addr_i[0] = 2'd1;
    wdata_i[0] = 16'h0F0F;
    push_exp(0, 1'b1, 16'h0000);
    req_i[0] = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    req_i[0] = 1'b0;
    repeat (25) @(posedge clk_i);
    #2;
    chk("pulse_acks", ack_cnt0, 1);
    chk("pulse_idle", busy_o, 0);

`ifdef HPI_LOCK_EN
    // Locked requester 0 gets two accesses before requester 1.
    @(negedge clk_i);
    reset_i = 1'b1;
    we_i = 2'b11;
    lock_i = 2'b01;
    req_i = 2'b11;
    push_exp(0, 1'b1, 16'h0000);
    push_exp(0, 1'b1, 16'h0000);
    push_exp(1, 1'b1, 16'h0000);
    @(negedge clk_i);
    reset_i = 1'b0;
    contend(3);
    lock_i = '0;
`endif

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
